// File: rtl/demux_1x4_buf_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer:
// lane count, select width, lane encodings and a one-hot lane decode helper.
package demux_1x4_buf_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_e;

  // One-hot decode of a lane number.
  function automatic logic [LANES-1:0] lane_onehot(input lane_e lane);
    logic [LANES-1:0] oh;
    oh = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1x4_buf_lane_buf.sv
// One-entry output buffer for a single demux lane.
// A load always wins over a drain, so a lane can be emptied and refilled in
// the same cycle and sustain one word per cycle. Data holds after a drain.
module lane_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Buffer state: load captures the word, drain only clears valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1x4_buf.sv
// Registered 1-to-4 demultiplexer with a one-entry buffer per lane.
// Optional feature macro: DEMUX_AUTO_SEL_EN -- when defined, sel is ignored
// and a round-robin pointer (advancing on each accept) chooses the lane.
module demux_1x4_buf
  import demux_1x4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic [LANES-1:0]       out_ready,
  output logic [SEL_W-1:0]       cur_sel
);

  logic             accept;
  logic [LANES-1:0] load;

`ifdef DEMUX_AUTO_SEL_EN
  logic [SEL_W-1:0] ptr;
  logic             unused_sel;

  assign unused_sel = ^sel;

  // Round-robin pointer: steps to the next lane on every accept, wraps 3->0,
  // and simply waits while the pointed-to lane is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr + 1'b1;
    end
  end

  assign cur_sel = ptr;
`else
  assign cur_sel = sel;
`endif

  // Ready when the target lane is empty or is being drained this cycle;
  // in_valid never feeds back into in_ready.
  always_comb begin
    in_ready = ~out_valid[cur_sel] | out_ready[cur_sel];
    accept   = in_valid & in_ready;
    load     = '0;
    if (accept) begin
      load = lane_onehot(lane_e'(cur_sel));
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_buf #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data     (in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Directed self-checking bench for demux_1x4_buf (WIDTH=4).
// Inputs change 2 time units after each rising edge; outputs are sampled there
// too, well away from the active edge.
module tb_demux_1x4_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_data;
  logic [1:0]  sel;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_ready;
  logic [1:0]  cur_sel;

  int unsigned total = 0;
  int unsigned bad   = 0;

  demux_1x4_buf #(
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .sel      (sel),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .cur_sel  (cur_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] expd;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sel       = '0;
    out_ready = '0;
    #12;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_data",  32'(out_data),  32'h0);
    chk("reset_ready", 32'(in_ready),  32'h1);
    rst = 1'b0;
    tick();

`ifdef DEMUX_AUTO_SEL_EN
    // Six accepts with sel tied to 00 and every consumer draining.
    expd = '0;
    out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      #1;
      chk("auto_cur_sel", 32'(cur_sel), 32'(i % 4));
      chk("auto_ready", 32'(in_ready), 32'h1);
      tick();
      expd[(i % 4)*4 +: 4] = 4'(i + 1);
      chk("auto_valid", 32'(out_valid), 32'(1 << (i % 4)));
      chk("auto_data", 32'(out_data), 32'(expd));
    end
    // Stop draining; fill lanes 2,3,0 so lane1 (still full) blocks the pointer.
    out_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      in_data = 4'(7 + i);
      tick();
      expd[((i + 2) % 4)*4 +: 4] = 4'(7 + i);
    end
    chk("auto_full_valid", 32'(out_valid), 32'hF);
    chk("auto_full_data", 32'(out_data), 32'(expd));
    for (int i = 0; i < 3; i++) begin
      chk("auto_block_sel", 32'(cur_sel), 32'h1);
      chk("auto_block_ready", 32'(in_ready), 32'h0);
      tick();
    end
    chk("auto_block_data", 32'(out_data), 32'(expd));
    in_valid = 1'b0;
`else
    // Routing: word A to lane2.
    sel = 2'b10; in_data = 4'hA; in_valid = 1'b1;
    #1;
    chk("route_ready", 32'(in_ready), 32'h1);
    chk("route_cur_sel", 32'(cur_sel), 32'h2);
    tick();
    chk("route_valid", 32'(out_valid), 32'h4);
    chk("route_data", 32'(out_data), 32'h0A00);

    // Fill lane0 so lanes 0 and 2 are full, then reset mid-stream.
    sel = 2'b00; in_data = 4'h5;
    tick();
    in_valid = 1'b0;
    chk("fill0_valid", 32'(out_valid), 32'h5);
    chk("fill0_data", 32'(out_data), 32'h0A05);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data", 32'(out_data), 32'h0);
    chk("midrst_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    tick();

    // Backpressure on lane1.
    sel = 2'b01; in_data = 4'h3; in_valid = 1'b1;
    tick();
    chk("bp_fill_valid", 32'(out_valid), 32'h2);
    chk("bp_fill_data", 32'(out_data), 32'h0030);
    in_data = 4'h7;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready_low", 32'(in_ready), 32'h0);
      tick();
      chk("bp_hold_data", 32'(out_data), 32'h0030);
    end
    out_ready = 4'b0010;
    #1;
    chk("bp_ready_high", 32'(in_ready), 32'h1);
    tick();
    chk("bp_load_valid", 32'(out_valid), 32'h2);
    chk("bp_load_data", 32'(out_data), 32'h0070);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", 32'(out_valid), 32'h0);
    chk("bp_drain_data", 32'(out_data), 32'h0070);
    out_ready = 4'b0000;

    // Streaming 1,2,3,4 into lane3 while it drains every cycle.
    sel = 2'b11; out_ready = 4'b1000; in_valid = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      in_data = 4'(w);
      #1;
      chk("stream_ready", 32'(in_ready), 32'h1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'h8);
      chk("stream_data", 32'(out_data), 32'h0070 | 32'(w << 12));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 32'(out_valid), 32'h0);
    chk("stream_end_data", 32'(out_data), 32'h4070);
    out_ready = 4'b0000;

    // Independence: lane0 drains on the same edge lane2 loads.
    sel = 2'b00; in_data = 4'h9; in_valid = 1'b1;
    tick();
    chk("ind_fill_valid", 32'(out_valid), 32'h1);
    sel = 2'b10; in_data = 4'h6; out_ready = 4'b0001;
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("ind_valid", 32'(out_valid), 32'h4);
    chk("ind_data", 32'(out_data), 32'h4679);

    // in_ready follows sel combinationally: full lane2 vs empty lane1.
    sel = 2'b10;
    #1;
    chk("sel_full_ready", 32'(in_ready), 32'h0);
    sel = 2'b01;
    #1;
    chk("sel_empty_ready", 32'(in_ready), 32'h1);
    expd = out_data;
    tick();
    chk("idle_hold_data", 32'(out_data), 32'(expd));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
